// File: rtl/reset_sequencer.sv
// Boot reset sequencer: strobes the PC write during reset hold, settles, optionally halts, then issues go_fetch.
// Latency: all outputs registered; go_fetch is high SETTLE_CYCLES edges after the hold-release edge.
// Backpressure: none; hold re-assertion pre-empts every other transition.
module reset_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic       clk1,
    input  logic       nreset,
    input  logic       nrsthold,
    input  logic       fphalt,
    input  logic       fpstart,
    output logic       nwpc,
    output logic       nirst,
    output logic       go_fetch,
    output logic       running,
    output logic       vecfail,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HALT   = 3'd3,
        ST_FETCH  = 3'd4,
        ST_RUN    = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_vec_wr;
    logic                 w_vec_wr_nxt;
    logic                 r_vecfail;
    logic                 w_vecfail_nxt;
    logic                 w_pc_wr;

    logic                 r_fph_s1;
    logic                 r_fph_s2;
    logic                 r_fps_s1;
    logic                 r_fps_s2;
    logic                 r_fps_s3;
    logic                 w_start_edge;

    logic                 r_nwpc;
    logic                 r_nirst;
    logic                 r_go_fetch;
    logic                 r_running;

    // Front-panel inputs are asynchronous: two-flop synchronisers, plus a third flop on start for edge detection.
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_fph_s1 <= 1'b0;
            r_fph_s2 <= 1'b0;
            r_fps_s1 <= 1'b0;
            r_fps_s2 <= 1'b0;
            r_fps_s3 <= 1'b0;
        end else begin
            r_fph_s1 <= fphalt;
            r_fph_s2 <= r_fph_s1;
            r_fps_s1 <= fpstart;
            r_fps_s2 <= r_fps_s1;
            r_fps_s3 <= r_fps_s2;
        end
    end

    assign w_start_edge = r_fps_s2 & ~r_fps_s3;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_vec_wr_nxt  = r_vec_wr;
        w_vecfail_nxt = r_vecfail;
        w_pc_wr       = 1'b0;

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!nrsthold) begin
                    w_pc_wr      = 1'b1;
                    w_vec_wr_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                    if (!r_vec_wr) begin
                        w_vecfail_nxt = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (nrsthold) begin
                    if (r_cnt == LP_CNT_LAST) begin
                        w_state_nxt = (r_vecfail || r_fph_s2) ? ST_HALT : ST_FETCH;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (nrsthold && w_start_edge && !r_vecfail) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase

        // Re-assertion wins over every other transition; the flag restarts and this cycle's PC write sets it.
        if (!nrsthold && (r_state == ST_SETTLE || r_state == ST_HALT ||
                          r_state == ST_FETCH  || r_state == ST_RUN)) begin
            w_state_nxt  = ST_HOLD;
            w_pc_wr      = 1'b1;
            w_vec_wr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_RST;
            r_cnt      <= '0;
            r_vec_wr   <= 1'b0;
            r_vecfail  <= 1'b0;
            r_nwpc     <= 1'b1;
            r_nirst    <= 1'b0;
            r_go_fetch <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_vec_wr   <= w_vec_wr_nxt;
            r_vecfail  <= w_vecfail_nxt;
            r_nwpc     <= ~w_pc_wr;
            r_nirst    <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_RUN);
            r_go_fetch <= (w_state_nxt == ST_FETCH);
            r_running  <= (w_state_nxt == ST_RUN);
        end
    end

    assign nwpc     = r_nwpc;
    assign nirst    = r_nirst;
    assign go_fetch = r_go_fetch;
    assign running  = r_running;
    assign vecfail  = r_vecfail;
    assign state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: boot paths, halt/start handling, hold re-assertion, async reset.
module tb_reset_sequencer;

    logic       clk1;
    logic       nreset;
    logic       nrsthold;
    logic       fphalt;
    logic       fpstart;
    logic       nwpc;
    logic       nirst;
    logic       go_fetch;
    logic       running;
    logic       vecfail;
    logic [2:0] state;

    int checks;
    int errors;

    int nwpc_lo;
    int go_cnt;
    int go_first;
    int run_first;
    int nirst_first;
    logic first_run;
    logic first_nirst;
    int seq[$];

    reset_sequencer #(.SETTLE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk1     (clk1),
        .nreset   (nreset),
        .nrsthold (nrsthold),
        .fphalt   (fphalt),
        .fpstart  (fpstart),
        .nwpc     (nwpc),
        .nirst    (nirst),
        .go_fetch (go_fetch),
        .running  (running),
        .vecfail  (vecfail),
        .state    (state)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic do_reset(input logic hold_lvl, input logic halt_lvl);
        nreset   = 1'b0;
        nrsthold = hold_lvl;
        fphalt   = halt_lvl;
        fpstart  = 1'b0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        nreset = 1'b1;
    endtask

    // Runs n edges, sampling 1 time unit after each edge; drives nrsthold/fpstart at given edge indices.
    task automatic observe(input int n, input int rel_at, input int fps_hi_at, input int fps_lo_at);
        seq.delete();
        seq.push_back(int'(state));
        nwpc_lo     = 0;
        go_cnt      = 0;
        go_first    = -1;
        run_first   = -1;
        nirst_first = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            #1;
            if (int'(state) != seq[$]) seq.push_back(int'(state));
            if (!nwpc) nwpc_lo++;
            if (go_fetch) begin
                if (go_cnt == 0) go_first = i;
                go_cnt++;
            end
            if (running && run_first < 0) run_first = i;
            if (nirst && nirst_first < 0) nirst_first = i;
            if (i == 0) begin
                first_run   = running;
                first_nirst = nirst;
            end
            if (i == rel_at)    nrsthold = 1'b1;
            if (i == fps_hi_at) fpstart  = 1'b1;
            if (i == fps_lo_at) fpstart  = 1'b0;
        end
    endtask

    task automatic test_reset;
        nreset   = 1'b0;
        nrsthold = 1'b0;
        fphalt   = 1'b0;
        fpstart  = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        checks++;
        if ({nwpc, nirst, go_fetch, running, vecfail, state} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got nwpc=%b nirst=%b go=%b run=%b vf=%b st=%0d, need 1 0 0 0 0 0",
                     nwpc, nirst, go_fetch, running, vecfail, state);
        end
    endtask

    task automatic test_nominal;
        int ok;
        do_reset(1'b0, 1'b0);
        observe(30, 16, -1, -1);
        checks++;
        if (nwpc_lo != 16) begin errors++; $display("FAIL nom_nwpc_cycles: got %0d need 16", nwpc_lo); end
        checks++;
        if (go_cnt != 1 || go_first != 21) begin
            errors++; $display("FAIL nom_go_fetch: got count %0d at %0d need 1 at 21", go_cnt, go_first);
        end
        checks++;
        if (nirst_first != 21) begin errors++; $display("FAIL nom_nirst_rise: got %0d need 21", nirst_first); end
        checks++;
        if (run_first != 22) begin errors++; $display("FAIL nom_running_rise: got %0d need 22", run_first); end
        ok = (seq.size() == 5) ? 1 : 0;
        if (ok == 1 && (seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 4 || seq[4] != 5)) ok = 0;
        checks++;
        if (ok == 0) begin
            errors++; $display("FAIL nom_state_seq: got %p need 0 1 2 4 5", seq);
        end
    endtask

    task automatic test_halted;
        do_reset(1'b0, 1'b1);
        observe(30, 16, -1, -1);
        checks++;
        if (go_cnt != 0 || state !== 3'd3) begin
            errors++; $display("FAIL halt_park: got go count %0d state %0d need 0 and 3", go_cnt, state);
        end
        checks++;
        if ({nirst, running, vecfail} !== 3'b000) begin
            errors++; $display("FAIL halt_outputs: got nirst/run/vf %b%b%b need 000", nirst, running, vecfail);
        end
        fpstart = 1'b1;
        observe(8, -1, -1, 1);
        checks++;
        if (go_cnt != 1 || go_first < 2 || go_first > 3) begin
            errors++; $display("FAIL halt_start: got count %0d at %0d need 1 at 2..3", go_cnt, go_first);
        end
        checks++;
        if (run_first != go_first + 1 || state !== 3'd5) begin
            errors++; $display("FAIL halt_run: got running at %0d state %0d need %0d and 5", run_first, state, go_first + 1);
        end
        fpstart = 1'b1;
        observe(10, -1, -1, 1);
        checks++;
        if (go_cnt != 0 || state !== 3'd5 || running !== 1'b1) begin
            errors++; $display("FAIL second_start: got go count %0d state %0d run %b need 0 5 1", go_cnt, state, running);
        end
    endtask

    task automatic test_reassert;
        fphalt   = 1'b0;
        nrsthold = 1'b0;
        observe(20, 4, -1, -1);
        checks++;
        if (first_run !== 1'b0 || first_nirst !== 1'b0 || seq.size() < 2 || seq[1] != 1) begin
            errors++; $display("FAIL reassert_entry: got run %b nirst %b need 0 0 and state 1", first_run, first_nirst);
        end
        checks++;
        if (nwpc_lo != 5) begin errors++; $display("FAIL reassert_nwpc: got %0d need 5", nwpc_lo); end
        checks++;
        if (go_cnt != 1 || go_first != 9 || run_first != 10) begin
            errors++; $display("FAIL reassert_go: got count %0d at %0d run %0d need 1 at 9 run 10", go_cnt, go_first, run_first);
        end
        checks++;
        if (state !== 3'd5 || vecfail !== 1'b0) begin
            errors++; $display("FAIL reassert_end: got state %0d vf %b need 5 0", state, vecfail);
        end
    endtask

    task automatic test_missing_vector;
        do_reset(1'b1, 1'b0);
        observe(20, -1, -1, -1);
        checks++;
        if (nwpc_lo != 0 || vecfail !== 1'b1) begin
            errors++; $display("FAIL missing_vec: got nwpc cycles %0d vf %b need 0 1", nwpc_lo, vecfail);
        end
        checks++;
        if (state !== 3'd3 || go_cnt != 0) begin
            errors++; $display("FAIL missing_halt: got state %0d go count %0d need 3 0", state, go_cnt);
        end
        fpstart = 1'b1;
        observe(10, -1, -1, 1);
        checks++;
        if (go_cnt != 0 || state !== 3'd3 || nirst !== 1'b0) begin
            errors++; $display("FAIL missing_start: got go count %0d state %0d nirst %b need 0 3 0", go_cnt, state, nirst);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1, 1'b0);
        repeat (2) @(posedge clk1);
        #1;
        checks++;
        if (state !== 3'd2 || vecfail !== 1'b1) begin
            errors++; $display("FAIL async_setup: got state %0d vf %b need 2 1", state, vecfail);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if ({nwpc, nirst, go_fetch, running, vecfail, state} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got nwpc=%b nirst=%b go=%b run=%b vf=%b st=%0d, need 1 0 0 0 0 0",
                     nwpc, nirst, go_fetch, running, vecfail, state);
        end
        @(negedge clk1);
        nreset = 1'b1;
    endtask

    task automatic test_settle_glitch;
        do_reset(1'b0, 1'b1);
        observe(16, 3, 4, 5);
        checks++;
        if (go_cnt != 0 || state !== 3'd3 || nwpc_lo != 3) begin
            errors++; $display("FAIL glitch_discard: got go count %0d state %0d nwpc %0d need 0 3 3", go_cnt, state, nwpc_lo);
        end
        fpstart = 1'b1;
        observe(8, -1, -1, 1);
        checks++;
        if (go_cnt != 1 || go_first < 2 || go_first > 3 || state !== 3'd5) begin
            errors++; $display("FAIL glitch_restart: got count %0d at %0d state %0d need 1 at 2..3 state 5", go_cnt, go_first, state);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nreset   = 1'b0;
        nrsthold = 1'b0;
        fphalt   = 1'b0;
        fpstart  = 1'b0;
        test_reset();
        test_nominal();
        test_halted();
        test_reassert();
        test_missing_vector();
        test_async_reset();
        test_settle_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
